// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder: one shared digit stage, LSD first, carry held between steps.
// Define BCD_SUB_EN to add the sub port for ten's-complement subtraction.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  carry_in,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  error
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StAdd, StDone} state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              c_q, c_d, carry_out_q, carry_out_d, error_q, error_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic              launch;
  logic [4:0]        t, t_adj;
  logic              c_next;
  logic [3:0]        digit;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

`ifdef BCD_SUB_EN
  function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    end
    return r;
  endfunction
`endif

  assign launch = start & ~start_q;

  // Operand registers shift right each step, so the active digit is always [3:0].
  // The > 9 test uses the full 5-bit sum (up to 19).
  always_comb begin
    t      = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
    c_next = (t > 5'd9);
    t_adj  = t + 5'd6;
    digit  = c_next ? t_adj[3:0] : t[3:0];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    error_d     = error_q;

    case (state_q)
      StIdle: begin
        if (launch) state_d = StLoad;
      end
      StLoad: begin
        a_d     = op_a;
        b_d     = op_b;
        c_d     = carry_in;
`ifdef BCD_SUB_EN
        if (sub) begin
          b_d = nines_comp(op_b);
          c_d = 1'b1;
        end
`endif
        sum_d   = '0;
        idx_d   = '0;
        error_d = has_bad_digit(op_a) | has_bad_digit(op_b);
        state_d = StAdd;
      end
      StAdd: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IdxW'(i)) sum_d[4*i +: 4] = digit;
        end
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = c_next;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(DIGITS - 1)) begin
          carry_out_d = c_next;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = launch ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      error_q     <= error_d;
    end
  end

  assign busy      = (state_q == StLoad) || (state_q == StAdd);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign error     = error_q;

endmodule
